tl_get_master: RTL and testbench

TileLink-UL initiator that turns a simple valid/ready word-read request stream into TileLink Get transactions on the A channel. It collects AccessAckData beats from the D channel into an in-order response queue. It sits between a client, such as a fetch unit or DMA reader, and the `tilelink` bus that the `rom` responder serves. This makes it the production replacement for the bench stimulator on the initiator side.

---
 rtl/tl_pkg.sv | 11 +
 rtl/tilelink.sv | 28 ++
 rtl/tl_rsp_fifo.sv | 46 ++++
 rtl/tl_get_master.sv | 80 ++++++++
 tb/tb_tl_get_master.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: TileLink-UL opcode constants and the response-queue entry type.
package tl_pkg;
  localparam logic [2:0] TL_GET = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK = 3'd0;
  localparam int TL_DATA_WIDTH = 64;
  typedef struct packed {
    logic err;
    logic [TL_DATA_WIDTH-1:0] data;
  } tl_rsp_t;
endpackage

// File: rtl/tilelink.sv
// tilelink: TileLink-UL A/D channel bundle shared by initiators and responders.
interface tilelink #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic a_valid;
  logic a_ready;
  logic [2:0] a_opcode;
  logic [2:0] a_param;
  logic [3:0] a_size;
  logic a_source;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [DATA_WIDTH/8-1:0] a_mask;
  logic [DATA_WIDTH-1:0] a_data;
  logic d_valid;
  logic d_ready;
  logic [2:0] d_opcode;
  logic d_denied;
  logic [DATA_WIDTH-1:0] d_data;
  modport initiator (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input a_ready, d_valid, d_opcode, d_denied, d_data
  );
  modport responder (
    input a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_denied, d_data
  );
endinterface

// File: rtl/tl_rsp_fifo.sv
// tl_rsp_fifo: DEPTH-entry synchronous FIFO with registered storage, no fall-through.
module tl_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter type T = tl_pkg::tl_rsp_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  T mem_q [DEPTH];
  T mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  always_comb begin
    full = cnt_q == (PW+1)'(DEPTH);
    empty = cnt_q == '0;
    pop_ok = pop && !empty;
    push_ok = push && (!full || pop_ok);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = din;
    wr_d = wr_q + PW'(push_ok);
    rd_d = rd_q + PW'(pop_ok);
    cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    dout = mem_q[rd_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tl_get_master.sv
// tl_get_master: turns a valid/ready word-read stream into TileLink Get transactions
// and returns AccessAckData beats in request order through a credit-limited queue.
module tl_get_master
  import tl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tilelink.initiator            bus,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  err_unexp
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic err;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;
  logic a_valid_q, a_valid_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [CW-1:0] credits_q, credits_d, outstanding_q, outstanding_d;
  logic err_unexp_q, err_unexp_d;
  logic req_fire, a_fire, d_fire, push, pop, full, empty;
  rsp_t din, dout;
  always_comb begin
    req_ready = !rst && credits_q != '0 && (!a_valid_q || bus.a_ready);
    req_fire = req_valid && req_ready;
    a_fire = a_valid_q && bus.a_ready;
    d_fire = bus.d_valid && !rst;
    pop = !empty && rsp_ready;
    push = d_fire && outstanding_q != '0 && (!full || pop);
    a_valid_d = req_fire || (a_valid_q && !bus.a_ready);
    a_addr_d = req_fire ? req_addr : a_addr_q;
    credits_d = credits_q + CW'(pop) - CW'(req_fire);
    outstanding_d = outstanding_q + CW'(a_fire) - CW'(push);
    // A beat with nothing outstanding is stale (e.g. issued before a reset): drop it.
    err_unexp_d = d_fire && outstanding_q == '0;
    din = '{err: bus.d_denied || bus.d_opcode != TL_ACCESS_ACK_DATA, data: bus.d_data};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_addr_q <= '0;
      credits_q <= CW'(DEPTH);
      outstanding_q <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_addr_q <= a_addr_d;
      credits_q <= credits_d;
      outstanding_q <= outstanding_d;
      err_unexp_q <= err_unexp_d;
    end
  end
  tl_rsp_fifo #(.DEPTH(DEPTH), .T(rsp_t)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(dout), .full(full), .empty(empty)
  );
  assign bus.a_valid = a_valid_q;
  assign bus.a_opcode = TL_GET;
  assign bus.a_param = 3'd0;
  assign bus.a_size = 4'($clog2(DATA_WIDTH/8));
  assign bus.a_source = 1'b0;
  assign bus.a_address = a_addr_q;
  assign bus.a_mask = '1;
  assign bus.a_data = '0;
  assign bus.d_ready = !rst;
  assign rsp_valid = !empty;
  assign rsp_data = dout.data;
  assign rsp_err = dout.err;
  assign err_unexp = err_unexp_q;
endmodule

// File: tb/tb_tl_get_master.sv
// tb_tl_get_master: directed checks of tl_get_master against a 1-cycle ROM responder.
module tb_tl_get_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [31:0] req_addr = 32'h0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic rsp_err;
  logic err_unexp;
  logic a_ready = 1'b1;
  logic resp_en = 1'b1;
  logic man_d = 1'b0;
  logic deny = 1'b0;
  logic bad_op = 1'b0;
  logic [31:0] rq[$];
  int rn = 0;
  logic [31:0] rhead = 32'h0;
  int afires = 0;
  int total = 0;
  int bad = 0;

  tilelink #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  tl_get_master #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .err_unexp(err_unexp)
  );

  // ROM contents: upper half A5A5_0000+addr, lower half 5A5A_0000+addr.
  function automatic logic [63:0] rom(input logic [31:0] a);
    return {32'hA5A5_0000 + a, 32'h5A5A_0000 + a};
  endfunction

  assign bus.a_ready = a_ready;
  assign bus.d_valid = man_d || (resp_en && rn != 0);
  assign bus.d_opcode = bad_op ? 3'd2 : 3'd1;
  assign bus.d_denied = deny;
  assign bus.d_data = (man_d && rn == 0) ? 64'hBAD0_BAD0_BAD0_BAD0 : rom(rhead);

  always @(posedge clk) begin
    if (bus.d_valid && bus.d_ready && resp_en && rn != 0) void'(rq.pop_front());
    if (bus.a_valid && bus.a_ready) begin
      rq.push_back(bus.a_address);
      afires <= afires + 1;
    end
    rn <= rq.size();
    rhead <= (rq.size() != 0) ? rq[0] : 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output logic ok);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    ok = rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++; if (bus.d_ready !== 1'b0) begin bad++; $display("FAIL reset_d_ready got=%b want=0", bus.d_ready); end
    total++; if (bus.a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b want=0", bus.a_valid); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    total++; if (err_unexp !== 1'b0) begin bad++; $display("FAIL reset_err_unexp got=%b want=0", err_unexp); end
    rst = 1'b0;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b want=1", req_ready); end
    total++; if (bus.d_ready !== 1'b1) begin bad++; $display("FAIL post_reset_d_ready got=%b want=1", bus.d_ready); end
    total++; if (dut.credits_q !== 3'd4) begin bad++; $display("FAIL post_reset_credits got=%0d want=4", dut.credits_q); end
  endtask

  task automatic test_single_read();
    a_ready = 1'b1; resp_en = 1'b1;
    req_valid = 1'b1; req_addr = 32'h100;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL single_req_ready got=%b want=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if (bus.a_valid !== 1'b1) begin bad++; $display("FAIL single_a_valid got=%b want=1", bus.a_valid); end
    total++; if (bus.a_opcode !== 3'd4) begin bad++; $display("FAIL single_a_opcode got=%0d want=4", bus.a_opcode); end
    total++; if (bus.a_size !== 4'd3) begin bad++; $display("FAIL single_a_size got=%0d want=3", bus.a_size); end
    total++; if (bus.a_address !== 32'h100) begin bad++; $display("FAIL single_a_address got=%h want=100", bus.a_address); end
    total++; if (bus.a_mask !== 8'hFF || bus.a_param !== 3'd0 || bus.a_source !== 1'b0 || bus.a_data !== 64'h0) begin
      bad++; $display("FAIL single_a_fixed mask=%h param=%0d source=%0d data=%h want ff/0/0/0", bus.a_mask, bus.a_param, bus.a_source, bus.a_data);
    end
    tick();
    total++; if (bus.a_valid !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_cycle2 a_valid=%b rsp_valid=%b want 0/0", bus.a_valid, rsp_valid); end
    tick();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid_cycle3 got=%b want=1", rsp_valid); end
    total++; if (rsp_data !== 64'hA5A5_0100_5A5A_0100) begin bad++; $display("FAIL single_rsp_data got=%h want=a5a501005a5a0100", rsp_data); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL single_rsp_err got=%b want=0", rsp_err); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%b want=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    int f0;
    logic ok;
    a_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h200;
    tick();
    req_addr = 32'h300;
    f0 = afires;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.a_valid !== 1'b1 || bus.a_address !== 32'h200 || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d a_valid=%b addr=%h req_ready=%b want 1/200/0", i, bus.a_valid, bus.a_address, req_ready);
      end
      tick();
    end
    req_valid = 1'b0; a_ready = 1'b1;
    tick();
    tick();
    tick();
    total++; if (afires - f0 !== 1) begin bad++; $display("FAIL bp_one_fire got=%0d want=1", afires - f0); end
    wait_rsp(ok);
    total++; if (!ok || rsp_data !== 64'hA5A5_0200_5A5A_0200) begin bad++; $display("FAIL bp_rsp valid=%b data=%h want a5a502005a5a0200", ok, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_credits();
    logic [31:0] addrs [6];
    logic [63:0] exp_data [5];
    int k;
    logic acc;
    logic ok;
    addrs = '{32'h0, 32'h8, 32'h10, 32'h18, 32'h20, 32'h28};
    exp_data = '{64'hA5A5_0000_5A5A_0000, 64'hA5A5_0008_5A5A_0008, 64'hA5A5_0010_5A5A_0010,
                 64'hA5A5_0018_5A5A_0018, 64'hA5A5_0020_5A5A_0020};
    k = 0;
    rsp_ready = 1'b0; a_ready = 1'b1;
    req_valid = 1'b1; req_addr = addrs[0];
    for (int i = 0; i < 10; i++) begin
      acc = req_ready;
      tick();
      if (acc) k++;
      req_addr = addrs[k];
    end
    total++; if (k !== 4) begin bad++; $display("FAIL credit_accepts got=%0d want=4", k); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL credit_req_ready got=%b want=0", req_ready); end
    total++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data[0]) begin bad++; $display("FAIL credit_full_head valid=%b data=%h want 1/%h", rsp_valid, rsp_data, exp_data[0]); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc = req_ready;
      tick();
      if (acc) k++;
      req_addr = addrs[k];
    end
    req_valid = 1'b0;
    total++; if (k !== 5) begin bad++; $display("FAIL credit_one_more got=%0d want=5", k); end
    for (int j = 1; j < 5; j++) begin
      wait_rsp(ok);
      total++; if (!ok || rsp_data !== exp_data[j] || rsp_err !== 1'b0) begin
        bad++; $display("FAIL credit_order idx=%0d valid=%b data=%h err=%b want %h/0", j, ok, rsp_data, rsp_err, exp_data[j]);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL credit_drained got=%b want=0", rsp_valid); end
  endtask

  task automatic test_denied();
    logic ok;
    deny = 1'b1;
    req_valid = 1'b1; req_addr = 32'h40;
    tick();
    req_valid = 1'b0;
    wait_rsp(ok);
    total++; if (!ok || rsp_err !== 1'b1) begin bad++; $display("FAIL denied_err valid=%b err=%b want 1/1", ok, rsp_err); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; deny = 1'b0; bad_op = 1'b1;
    req_valid = 1'b1; req_addr = 32'h50;
    tick();
    req_valid = 1'b0;
    wait_rsp(ok);
    total++; if (!ok || rsp_err !== 1'b1) begin bad++; $display("FAIL badop_err valid=%b err=%b want 1/1", ok, rsp_err); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; bad_op = 1'b0;
    req_valid = 1'b1; req_addr = 32'h48;
    tick();
    req_valid = 1'b0;
    wait_rsp(ok);
    total++; if (!ok || rsp_err !== 1'b0 || rsp_data !== 64'hA5A5_0048_5A5A_0048) begin
      bad++; $display("FAIL denied_followup valid=%b err=%b data=%h want 1/0/a5a500485a5a0048", ok, rsp_err, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_unexpected();
    int pulses;
    logic rv;
    pulses = 0; rv = 1'b0;
    man_d = 1'b1;
    tick();
    man_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (err_unexp) pulses++;
      if (rsp_valid) rv = 1'b1;
      tick();
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL unexp_pulse got=%0d want=1", pulses); end
    total++; if (rv !== 1'b0) begin bad++; $display("FAIL unexp_rsp_valid got=%b want=0", rv); end
    total++; if (dut.credits_q !== 3'd4) begin bad++; $display("FAIL unexp_credits got=%0d want=4", dut.credits_q); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_data [4];
    int j;
    exp_data = '{64'hA5A5_0080_5A5A_0080, 64'hA5A5_0088_5A5A_0088, 64'hA5A5_0090_5A5A_0090, 64'hA5A5_0098_5A5A_0098};
    a_ready = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1;
    j = 0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h80 + 32'(8 * i);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_req_ready cyc=%0d got=%b want=1", i, req_ready); end
      if (rsp_valid && j < 4) begin
        total++; if (rsp_data !== exp_data[j]) begin bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", j, rsp_data, exp_data[j]); end
        j++;
      end
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid && j < 4) begin
        total++; if (rsp_data !== exp_data[j]) begin bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", j, rsp_data, exp_data[j]); end
        j++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    total++; if (j !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", j); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic rv;
    logic ok;
    resp_en = 1'b0; a_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h60;
    tick();
    req_addr = 32'h68;
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (dut.outstanding_q !== 3'd2) begin bad++; $display("FAIL mid_outstanding_before got=%0d want=2", dut.outstanding_q); end
    rst = 1'b1;
    tick();
    total++; if (bus.a_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 64'h0 || rsp_err !== 1'b0 || err_unexp !== 1'b0 || req_ready !== 1'b0 || bus.d_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outputs a_valid=%b rsp_valid=%b data=%h err=%b unexp=%b req_ready=%b d_ready=%b want all 0", bus.a_valid, rsp_valid, rsp_data, rsp_err, err_unexp, req_ready, bus.d_ready);
    end
    total++; if (dut.credits_q !== 3'd4 || dut.outstanding_q !== 3'd0) begin bad++; $display("FAIL mid_reset_counters credits=%0d outstanding=%0d want 4/0", dut.credits_q, dut.outstanding_q); end
    rst = 1'b0;
    resp_en = 1'b1;
    pulses = 0; rv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (err_unexp) pulses++;
      if (rsp_valid) rv = 1'b1;
    end
    total++; if (pulses !== 2) begin bad++; $display("FAIL mid_late_beats got=%0d want=2", pulses); end
    total++; if (rv !== 1'b0) begin bad++; $display("FAIL mid_late_rsp_valid got=%b want=0", rv); end
    req_valid = 1'b1; req_addr = 32'h70;
    tick();
    req_valid = 1'b0;
    wait_rsp(ok);
    total++; if (!ok || rsp_data !== 64'hA5A5_0070_5A5A_0070 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL mid_new_read valid=%b data=%h err=%b want 1/a5a500705a5a0070/0", ok, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_backpressure();
    test_credits();
    test_denied();
    test_unexpected();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
